// File: rtl/uart_tx_arbiter.sv
// Per-message round-robin arbiter sharing one UART TX byte port among NUM_REQ requesters.
// Optional idle-grant timeout release is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int         NUM_REQ        = 4,
  parameter int         MAX_MSG_LEN    = 64,
  parameter logic [7:0] EOM_BYTE       = 8'h0D,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [8*NUM_REQ-1:0] in_data,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 trunc,
  output logic                 timeout
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req for the next message
  // GRANT | owner streams bytes until EOM, length limit or timeout
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [IW-1:0]      owner, owner_n, last, last_n, pick, cidx;
  logic [7:0]         cnt, cnt_n;
  logic               trunc_n, timeout_n, found, xfer, is_eom, at_max, tmo_hit;
  int                 cand;

  // Zero-latency byte mux from the owner; grant is one-hot or zero.
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        tx_data  = in_data[8*i +: 8];
        tx_valid = in_valid[i];
      end
    end
  end

  assign in_ready = grant & {NUM_REQ{tx_ready}};
  assign busy     = (state == GRANT);
  assign xfer     = tx_valid & tx_ready;
  assign is_eom   = (tx_data == EOM_BYTE);
  assign at_max   = (cnt == 8'(MAX_MSG_LEN - 1));

  // Search upward from last+1 with wrap, so the previous owner ranks lowest.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts only while the owner has nothing to offer; a stalled serializer does not count.
  always_ff @(posedge clk) begin
    if (rst || state != GRANT || xfer || tmo_hit) tmo_cnt <= '0;
    else if (!tx_valid)                           tmo_cnt <= tmo_cnt + TW'(1);
  end

  assign tmo_hit = (state == GRANT) && !tx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    owner_n   = owner;
    last_n    = last;
    cnt_n     = cnt;
    trunc_n   = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (found) begin
          state_n       = GRANT;
          owner_n       = pick;
          grant_n       = '0;
          grant_n[pick] = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) cnt_n = cnt + 8'd1;
        if (xfer && (is_eom || at_max)) begin
          state_n = IDLE;
          grant_n = '0;
          last_n  = owner;
          trunc_n = !is_eom;
        end else if (tmo_hit) begin
          state_n   = IDLE;
          grant_n   = '0;
          last_n    = owner;
          timeout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      last    <= IW'(NUM_REQ - 1);
      cnt     <= '0;
      trunc   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      owner   <= owner_n;
      last    <= last_n;
      cnt     <= cnt_n;
      trunc   <= trunc_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter (4 requesters, MAX_MSG_LEN=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req, in_valid, in_ready, grant;
  logic [31:0] in_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy, trunc, timeout;

  logic [3:0]  req_man, req_auto, nonempty, pop_mask;
  logic [7:0]  src_mem [4][64];
  logic [5:0]  src_rd [4];
  logic [5:0]  src_wr [4];
  exp_t        sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int n_trunc = 0;
  int n_tmo = 0;
  int t0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .MAX_MSG_LEN(4), .EOM_BYTE(8'h0D), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .trunc(trunc), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester sources: each offers the head of its byte FIFO whenever it is non-empty.
  always_comb begin
    nonempty = '0;
    req      = '0;
    in_valid = '0;
    in_data  = '0;
    for (int i = 0; i < 4; i++) begin
      nonempty[i]       = (src_rd[i] != src_wr[i]);
      req[i]            = req_man[i] | (req_auto[i] & nonempty[i]);
      in_valid[i]       = nonempty[i];
      in_data[8*i +: 8] = src_mem[i][src_rd[i]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input int r, input logic [7:0] b, input bit push);
    exp_t e;
    src_mem[r][src_wr[r]] = b;
    src_wr[r] = src_wr[r] + 6'd1;
    if (push) begin
      e.g = 4'(1 << r);
      e.d = b;
      sb.push_back(e);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_rd[i] = '0;
      src_wr[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_man = '0;
    req_auto = '0;
    tx_ready = 1'b0;
    clear_src();
    sb.delete();
    step(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && k < 200) begin
      step();
      k++;
    end
    check(tag, 32'(sb.size() == 0 && busy === 1'b0), 32'd1);
  endtask

  // Monitor: scoreboard on the TX side, pulse counters, and source pops after each edge.
  initial begin
    exp_t e;
    pop_mask = '0;
    forever begin
      @(negedge clk);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("unexpected_xfer", {grant, 20'd0, tx_data}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("tx_data", 32'(tx_data), 32'(e.d));
          check("byte_owner", 32'(grant), 32'(e.g));
        end
      end
      if (trunc === 1'b1) n_trunc++;
      if (timeout === 1'b1) n_tmo++;
      pop_mask = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (pop_mask[i] === 1'b1) src_rd[i] = src_rd[i] + 6'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) for (int j = 0; j < 64; j++) src_mem[i][j] = 8'h00;
    req_man = '0;
    req_auto = '0;
    tx_ready = 1'b0;
    rst = 1'b1;
    clear_src();

    // Reset state
    do_reset();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_trunc_timeout", 32'({trunc, timeout}), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_tx_data_known", 32'($isunknown(tx_data)), 32'h0);

    // Requester 0 wins first, sends "HI\r"; requester 2 follows after one idle cycle
    load(0, 8'h48, 1); load(0, 8'h49, 1); load(0, 8'h0D, 1);
    load(2, 8'h5A, 1); load(2, 8'h0D, 1);
    req_auto = 4'b0101;
    tx_ready = 1'b1;
    step();
    check("t1_grant0", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_first_byte", 32'(tx_data), 32'h48);
    t0 = n_xfer;
    step(3);
    check("t1_three_xfers", 32'(n_xfer - t0), 32'd3);
    check("t1_idle_gap", 32'({busy, grant}), 32'h0);
    step();
    check("t1_grant2", 32'(grant), 32'h4);
    wait_drain("t1_drain");

    // All four requesting: order 0,1,2,3,0, messages never interleaved
    do_reset();
    load(0, 8'h61, 1); load(0, 8'h0D, 1);
    load(1, 8'h62, 1); load(1, 8'h0D, 1);
    load(2, 8'h63, 1); load(2, 8'h0D, 1);
    load(3, 8'h64, 1); load(3, 8'h0D, 1);
    load(0, 8'h65, 1); load(0, 8'h0D, 1);
    req_auto = 4'b1111;
    tx_ready = 1'b1;
    t0 = n_xfer;
    wait_drain("t2_drain");
    check("t2_xfer_count", 32'(n_xfer - t0), 32'd10);
    req_auto = '0;

    // Owner 1 with tx_ready 1,0,1 and req dropped after the first byte
    load(1, 8'h31, 1); load(1, 8'h32, 1); load(1, 8'h0D, 1);
    req_man = 4'b0010;
    step();
    check("t3_grant1", 32'(grant), 32'h2);
    check("t3_in_ready_hi", 32'(in_ready), 32'h2);
    step();
    req_man = '0;
    tx_ready = 1'b0;
    #1;
    check("t3_in_ready_lo", 32'(in_ready), 32'h0);
    check("t3_second_byte", 32'(tx_data), 32'h32);
    step();
    check("t3_grant_held", 32'(grant), 32'h2);
    tx_ready = 1'b1;
    #1;
    check("t3_in_ready_back", 32'(in_ready), 32'h2);
    step();
    check("t3_eom_offered", 32'(tx_data), 32'h0D);
    step();
    check("t3_released", 32'(grant), 32'h0);
    wait_drain("t3_drain");

    // EOM landing exactly on byte MAX_MSG_LEN is a normal release
    t0 = n_trunc;
    load(0, 8'h41, 1); load(0, 8'h42, 1); load(0, 8'h43, 1); load(0, 8'h0D, 1);
    req_auto = 4'b0001;
    wait_drain("t4a_drain");
    check("t4a_no_trunc", 32'(n_trunc - t0), 32'd0);
    req_auto = '0;

    // Truncation: 5 bytes without EOM, only 4 pass under this grant
    t0 = n_trunc;
    for (int b = 0; b < 5; b++) load(2, 8'(8'h41 + b), b < 4);
    req_man = 4'b0100;
    step();
    check("t4_grant2", 32'(grant), 32'h4);
    req_man = '0;
    step(3);
    check("t4_pre_release", 32'({trunc, grant}), 32'h4);
    step();
    check("t4_release", 32'({trunc, grant}), 32'h10);
    check("t4_last_byte_left", 32'(src_wr[2] - src_rd[2]), 32'd1);
    step();
    check("t4_trunc_one_cycle", 32'({trunc, grant}), 32'h0);
    check("t4_trunc_count", 32'(n_trunc - t0), 32'd1);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    src_rd[2] = src_wr[2];

    // Reset while requester 3 is mid-message; pointer returns to its reset value
    load(3, 8'h51, 1); load(3, 8'h52, 0); load(3, 8'h0D, 0);
    req_man = 4'b1000;
    step();
    check("t5_grant3", 32'(grant), 32'h8);
    step();
    tx_ready = 1'b0;
    rst = 1'b1;
    step();
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    rst = 1'b0;
    req_man = '0;
    tx_ready = 1'b1;
    clear_src();
    load(0, 8'h41, 1); load(0, 8'h0D, 1);
    load(3, 8'h51, 1); load(3, 8'h0D, 1);
    req_auto = 4'b1001;
    step();
    check("t5_ptr_reset", 32'(grant), 32'h1);
    wait_drain("t5_drain");
    req_auto = '0;

    // Owner 0 sends one byte then goes silent
    load(0, 8'h41, 1);
    req_man = 4'b0001;
    step();
    check("t6_grant0", 32'(grant), 32'h1);
    step();
    check("t6_silent", 32'(tx_valid), 32'h0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    t0 = n_tmo;
    step(15);
    check("t6_pre_timeout", 32'({timeout, grant}), 32'h1);
    step();
    check("t6_timeout", 32'({timeout, grant}), 32'h10);
    req_man = '0;
    step();
    check("t6_timeout_pulse", 32'(n_tmo - t0), 32'd1);
    check("t6_after", 32'({timeout, grant}), 32'h0);
`else
    step(120);
    check("t6_grant_held", 32'({timeout, busy, grant}), 32'h11);
    do_reset();
    check("t6_reset_release", 32'(grant), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte interface between NUM_REQ requesters (e.g. debug console, status reporter, command echo).
- Arbitration is per message, not per byte. A message is a byte stream terminated by carriage return 0x0D.
- Grant is held until the terminator transfers, so lines never interleave on the serial link.
- Sits between requester byte streams and the UART TX serializer's valid/ready byte port.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_MSG_LEN, 64: max bytes per grant including the terminator, 2..255; forced release when reached.
- EOM_BYTE, 8'h0D: end-of-message byte.
- TIMEOUT_CYCLES, 1000000: idle-grant timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester message request, level.
- in_valid  in  NUM_REQ  per-requester byte valid.
- in_data  in  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i].
- in_ready  out  NUM_REQ  per-requester byte accept.
- tx_data  out  8  byte to UART TX serializer.
- tx_valid  out  1  byte valid to serializer.
- tx_ready  in  1  serializer can accept a byte.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high in GRANT state.
- trunc  out  1  one-cycle pulse on forced release at MAX_MSG_LEN.
- timeout  out  1  one-cycle pulse on timeout release; tied 0 without the feature.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; grant=0, busy=0, trunc=0, timeout=0, byte count=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-message: tx_valid and in_ready are 0 from the following cycle. The partial message is abandoned and no terminator is injected.
- States: IDLE, GRANT.
- IDLE:
  - tx_valid=0, in_ready=0.
  - If any req bit is high, choose the first set bit searching from last+1 upward with wrap-around.
  - grant and busy are registered: req seen at edge t gives grant at t+1.
  - Byte count is cleared.
- GRANT (owner g):
  - Combinational mux, zero added latency: tx_data=in_data[g], tx_valid=in_valid[g], in_ready[g]=tx_ready. All other in_ready bits are 0.
  - A transfer is tx_valid & tx_ready at a clk edge. Each transfer increments the byte count.
  - A transfer with byte==EOM_BYTE: state goes to IDLE, last=g, grant=0 next cycle.
  - A transfer of byte number MAX_MSG_LEN that is not EOM_BYTE: same release, plus trunc pulse for 1 cycle. If that byte equals EOM_BYTE, there is no trunc.
  - Owner dropping req mid-message does not release the grant; only EOM, truncation, timeout or reset release it.
  - Other requesters' req changes are ignored until IDLE.
- Back-to-back:
  - Release at edge t, IDLE at t+1, new grant at t+2.
  - Minimum one idle cycle between messages; the bus is never handed over in the same cycle.
- Fairness:
  - A requester just served has lowest priority next round.
  - With all NUM_REQ requesting, each is served once per NUM_REQ messages.
- tx_data when tx_valid=0 is don't-care, but it must not be X after reset; drive it from the mux or 0.
- The byte count is 8 bits and never wraps, because MAX_MSG_LEN<=255 forces release first.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in GRANT while in_valid[g]=0. It clears on any transfer and on entering GRANT.
  - On reaching TIMEOUT_CYCLES: release to IDLE, last=g, timeout pulses 1 cycle. No EOM is injected.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - A stalled serializer (tx_ready=0 with in_valid=1) does not count.
- Undefined:
  - No counter logic; timeout is tied to 0.
  - An owner that stops sending holds the grant indefinitely.

Test Plan:
- Reset then req=4'b0101 at edge t → grant=4'b0001 at t+1. Requester 0 sends "HI",0x0D with tx_ready=1 → tx_data 0x48,0x49,0x0D on 3 consecutive edges. grant=0 one cycle, then grant=4'b0100.
- req=4'b1111 held, each requester sends a 2-byte message "x",0x0D → grant order 0,1,2,3,0. Each message appears contiguously on tx_data, never interleaved.
- Owner 1 mid-message with tx_ready toggling 1,0,1 → in_ready[1] mirrors tx_ready; no byte lost or duplicated. Owner drops req after byte 1 → grant stays 4'b0010 until 0x0D transfers.
- MAX_MSG_LEN=4, requester 2 sends 5 non-0x0D bytes 0x41..0x45 → release after 0x44 with trunc=1 for exactly 1 cycle. 0x45 is not accepted under this grant.
- rst=1 asserted while requester 3 is mid-message → grant=0, tx_valid=0 next cycle. Next arbitration with req=4'b1000 grants requester 3; pointer is back at reset value.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, owner 0 sends 0x41 then holds in_valid=0 → timeout pulses 16 cycles after the last transfer, grant=0. Without the macro, grant holds for 100+ cycles.
